// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Holds the FSM state encoding, the slice width and the counter-width helper.
// Pure declarations; no logic of its own.
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the pass counter; never narrower than one bit.
  function automatic int cnt_w(input int nibs);
    return (nibs > 1) ? $clog2(nibs) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
// op_sub exists only when NSA_SUB_EN is defined.
// master = operand producer / result consumer, slave = the controller.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef NSA_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, out_ready,
`ifdef NSA_SUB_EN
    output op_sub,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef NSA_SUB_EN
    input  op_sub,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder slice with explicit carry in.
// Latency: zero cycles (pure combinational).
// No flow control; the controller decides when its output is used.
module nibble_add_slice
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  // Ripple the carry bit by bit from cin up to cout.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add (or a-b with NSA_SUB_EN) using one 4-bit slice, LS nibble first.
// Latency: out_valid rises NIBS cycles after the accept edge; NIBS+2 cycles per op.
// Backpressure: result holds in DONE until out_ready; in_ready is low while busy.
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus,
  output logic                    busy
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int CNT_W = cnt_w(NIBS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBS - 1);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;
  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;
  logic             last_pass;
  logic             init_carry;
  logic [WIDTH-1:0] b_load;

  // Subtraction is a + ~b + 1: invert B at load and seed the carry with 1.
`ifdef NSA_SUB_EN
  assign init_carry = bus.op_sub;
  assign b_load     = bus.op_sub ? ~bus.b : bus.b;
`else
  assign init_carry = 1'b0;
  assign b_load     = bus.b;
`endif

  nibble_add_slice u_slice (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_pass = (cnt == LAST_CNT);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and handshake outputs; in_ready is only high in IDLE.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_pass) state_nx = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand shifting, carry chaining and result capture on the last pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= b_load;
            carry <= init_carry;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= {slice_sum, sum_sh[WIDTH-1:NIB_W]};
          carry  <= slice_cout;
          a_sh   <= a_sh >> NIB_W;
          b_sh   <= b_sh >> NIB_W;
          cnt    <= cnt + CNT_W'(1);
          if (last_pass) begin
            sum_q  <= {slice_sum, sum_sh[WIDTH-1:NIB_W]};
            cout_q <= slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
